// File: rtl/pixel_uart_streamer_pkg.sv
// Shared types and constants for the pixel UART streamer.
// PIXEL_UART_PARITY_EN selects an 11-bit frame that carries an even-parity bit.
package pixel_uart_streamer_pkg;

  localparam logic UART_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam int unsigned DATA_BITS = 8;

`ifdef PIXEL_UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  // Pixel sequencing; S_SEND spans the start, data and stop bits of one byte.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_DONE
  } stream_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/pixel_uart_streamer_if.sv
// Result-RAM read port: strobe and address out, data back one clock later.
interface pixel_uart_streamer_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 24
) ();

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/pixel_uart_streamer_uart_byte_tx.sv
// Single-byte UART transmitter, LSB first, with registered line output.
// PIXEL_UART_PARITY_EN inserts an even-parity bit between bit 7 and the stop bit.
module uart_byte_tx
  import pixel_uart_streamer_pkg::*;
#(
  parameter int unsigned TICK_PER_HALF = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam logic [15:0] TICK_LAST = 16'(2 * TICK_PER_HALF - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        bit_end;
`ifdef PIXEL_UART_PARITY_EN
  logic        par_q, par_d;
`endif

  assign bit_end = (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= UART_IDLE;
`ifdef PIXEL_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef PIXEL_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // The line value for the next bit is loaded at the edge that ends the
  // current one, so the tick counter restarts at zero on every boundary.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_o  = 1'b0;
`ifdef PIXEL_UART_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != TX_IDLE) begin
      tick_d = bit_end ? '0 : tick_q + 16'd1;
    end
    case (state_q)
      TX_IDLE: begin
        if (valid_i) begin
          state_d = TX_START;
          tick_d  = '0;
          bit_d   = '0;
          shreg_d = byte_i;
          tx_d    = START_LVL;
`ifdef PIXEL_UART_PARITY_EN
          par_d   = ^byte_i;
`endif
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef PIXEL_UART_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            tx_d    = STOP_LVL;
`endif
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef PIXEL_UART_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          tx_d    = STOP_LVL;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          state_d = TX_IDLE;
          tx_d    = UART_IDLE;
          done_o  = 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = UART_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != TX_IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/pixel_uart_streamer.sv
// Reads pixel words from the result RAM and streams each one as BPP UART
// bytes, least significant byte first; signals done after the final stop bit.
module pixel_uart_streamer
  import pixel_uart_streamer_pkg::*;
#(
  parameter int unsigned BPP           = 3,
  parameter int unsigned PIXELS        = 225,
  parameter int unsigned AW            = 10,
  parameter int unsigned TICK_PER_HALF = 2604
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  pixel_uart_streamer_if.master  ram,
  output logic                   tx,
  output logic                   tx_active,
  output logic                   done
);

  localparam int unsigned PW = 8 * BPP;
  localparam int unsigned IW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(BPP - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(PIXELS - 1);

  stream_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic          byte_valid;
  logic          byte_busy;
  logic          byte_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    active_d   = active_q;
    done_d     = done_q;
    byte_valid = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_FETCH;
          addr_d   = '0;
          active_d = 1'b1;
          done_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        pix_d   = ram.rd_data;
        idx_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!byte_busy) begin
          byte_valid = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        // Shifting the pixel right keeps the next byte in the low lane.
        if (byte_done) begin
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 1'b1;
            pix_d   = pix_q >> 8;
            state_d = S_LOAD;
          end else if (addr_q < ADDR_LAST) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            active_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram.rd_en   = (state_q == S_FETCH);
  assign ram.rd_addr = addr_q;
  assign tx_active   = active_q;
  assign done        = done_q;

  uart_byte_tx #(
    .TICK_PER_HALF(TICK_PER_HALF)
  ) u_byte_tx (
    .clk    (clk),
    .rst    (rst),
    .valid_i(byte_valid),
    .byte_i (pix_q[7:0]),
    .busy_o (byte_busy),
    .done_o (byte_done),
    .tx_o   (tx)
  );

endmodule

// File: tb/tb_pixel_uart_streamer.sv
// Directed bench: a 1-pixel and a 4-pixel streamer share one clock and reset.
// With PIXEL_UART_PARITY_EN defined the receiver also checks the parity bit.
module tb_pixel_uart_streamer;
  import pixel_uart_streamer_pkg::*;

  localparam int unsigned TPH      = 2;
  localparam int unsigned BIT_CLKS = 2 * TPH;
  localparam int unsigned AW       = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start4;
  logic tx1, act1, done1;
  logic tx4, act4, done4;

  pixel_uart_streamer_if #(.AW(AW), .DW(24)) ram1 ();
  pixel_uart_streamer_if #(.AW(AW), .DW(24)) ram4 ();

  pixel_uart_streamer #(.BPP(3), .PIXELS(1), .AW(AW), .TICK_PER_HALF(TPH)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ram(ram1),
    .tx(tx1), .tx_active(act1), .done(done1)
  );

  pixel_uart_streamer #(.BPP(3), .PIXELS(4), .AW(AW), .TICK_PER_HALF(TPH)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ram(ram4),
    .tx(tx4), .tx_active(act4), .done(done4)
  );

  // Result RAMs with one-clock read latency.
  always @(posedge clk) if (ram1.rd_en) ram1.rd_data <= 24'hA5_3C_01;
  always @(posedge clk) if (ram4.rd_en) ram4.rd_data <= 24'(ram4.rd_addr) * 24'h010101;

  int unsigned addr_log[$];
  logic        addr_over = 1'b0;
  always @(posedge clk) if (ram4.rd_en) addr_log.push_back(32'(ram4.rd_addr));
  always @(negedge clk) if (ram4.rd_addr >= 10'd4) addr_over = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 1) ? tx1 : tx4;
  endfunction

  function automatic logic active(input int sel);
    return (sel == 1) ? act1 : act4;
  endfunction

  task automatic pulse(input int sel);
    if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Waits for a start bit, then samples every clock of every bit; returns on
  // the negedge of the last stop-bit clock.
  task automatic rx_byte(input int sel, input logic [7:0] exp, input int gap_lim, input string tag);
    int   gap;
    logic [7:0] b;
    logic stable;
    gap = 0;
    @(negedge clk);
    while (line(sel) !== 1'b0 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    if (line(sel) !== 1'b0) begin
      check_val({tag, "_start_timeout"}, 32'd1, 32'd0);
      return;
    end
    if (gap_lim >= 0) check_val({tag, "_gap_ok"}, 32'(gap <= gap_lim), 32'd1);
    check_val({tag, "_active"}, 32'(active(sel)), 32'd1);
    stable = 1'b1;
    for (int c = 1; c < BIT_CLKS; c++) begin
      @(negedge clk);
      if (line(sel) !== 1'b0) stable = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b[k] = line(sel);
      for (int c = 1; c < BIT_CLKS; c++) begin
        @(negedge clk);
        if (line(sel) !== b[k]) stable = 1'b0;
      end
    end
`ifdef PIXEL_UART_PARITY_EN
    for (int c = 0; c < BIT_CLKS; c++) begin
      @(negedge clk);
      if (line(sel) !== ^exp) stable = 1'b0;
    end
`endif
    for (int c = 0; c < BIT_CLKS; c++) begin
      @(negedge clk);
      if (line(sel) !== STOP_LVL) stable = 1'b0;
    end
    check_val({tag, "_data"}, 32'(b), 32'(exp));
    check_val({tag, "_bit_timing"}, 32'(stable), 32'd1);
    check_val({tag, "_active_stop"}, 32'(active(sel)), 32'd1);
  endtask

  task automatic run4(input bit poke, input string tag);
    int lim;
    addr_log.delete();
    pulse(4);
    for (int i = 0; i < 12; i++) begin
      lim = (i == 0) ? -1 : ((i % 3 == 0) ? 4 : 2);
      if (poke && i == 5) begin
        fork
          rx_byte(4, 8'(i / 3), lim, $sformatf("%s_b%0d", tag, i));
          begin
            repeat (12) @(negedge clk);
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
          end
        join
      end else begin
        rx_byte(4, 8'(i / 3), lim, $sformatf("%s_b%0d", tag, i));
      end
    end
    @(negedge clk);
    check_val({tag, "_done"}, 32'(done4), 32'd1);
    check_val({tag, "_active_end"}, 32'(act4), 32'd0);
    check_val({tag, "_nreads"}, 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check_val($sformatf("%s_addr%0d", tag, i), addr_log[i], 32'(i));
    check_val({tag, "_addr_over"}, 32'(addr_over), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    start1 = 1'b0;
    start4 = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_val("rst_tx4", 32'(tx4), 32'd1);
      check_val("rst_act4", 32'(act4), 32'd0);
      check_val("rst_done4", 32'(done4), 32'd0);
      check_val("rst_rden4", 32'(ram4.rd_en), 32'd0);
      check_val("rst_tx1", 32'(tx1), 32'd1);
    end
    check_val("rst_addr4", 32'(ram4.rd_addr), 32'd0);
    check_val("rst_done1", 32'(done1), 32'd0);

    // Single pixel: bytes 01, 3C, A5.
    pulse(1);
    rx_byte(1, 8'h01, -1, "p1_b0");
    rx_byte(1, 8'h3C, 2, "p1_b1");
    rx_byte(1, 8'hA5, 2, "p1_b2");
    @(negedge clk);
    check_val("p1_done", 32'(done1), 32'd1);
    check_val("p1_active_end", 32'(act1), 32'd0);
    check_val("p1_tx_idle", 32'(tx1), 32'd1);
    repeat (20) @(negedge clk);
    check_val("p1_done_held", 32'(done1), 32'd1);

    // Multi-pixel, then the same with a start pulse during byte 5.
    run4(1'b0, "p4");
    run4(1'b1, "p4poke");

    // Reset during data bits of byte 2.
    pulse(4);
    rx_byte(4, 8'h00, -1, "rs_b0");
    rx_byte(4, 8'h00, 2, "rs_b1");
    low_cnt = 0;
    while (tx4 !== 1'b0 && low_cnt < 50) begin
      low_cnt++;
      @(negedge clk);
    end
    check_val("rs_b2_started", 32'(tx4), 32'd0);
    repeat (BIT_CLKS + 6) @(negedge clk);
    check_val("rs_in_data", 32'(act4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rs_tx", 32'(tx4), 32'd1);
    check_val("rs_active", 32'(act4), 32'd0);
    check_val("rs_done", 32'(done4), 32'd0);
    check_val("rs_addr", 32'(ram4.rd_addr), 32'd0);
    low_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || act4 !== 1'b0) low_cnt++;
    end
    check_val("rs_quiet", 32'(low_cnt), 32'd0);
    run4(1'b0, "rs_resend");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
